// File: rtl/lat_command_decoder_if.sv
// Serial command bus seen by the LAT decoder: SCLK/LAT/SIN from the
// writer under observation plus the decoder's result signals.
interface lat_command_decoder_if #(
  parameter int DATA_W = 48
);
  logic              SCLK;
  logic              LAT;
  logic              SIN;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] fc_reg;
  logic              fc_update;
  logic              fcwrten_armed;
  logic              cmd_err;

  // Driver side: the serial writer (or a bench) that owns SCLK/LAT/SIN.
  modport master (
    output SCLK, LAT, SIN,
    input  cmd_valid, cmd, cmd_data, fc_reg, fc_update, fcwrten_armed, cmd_err
  );

  // Decoder side.
  modport slave (
    input  SCLK, LAT, SIN,
    output cmd_valid, cmd, cmd_data, fc_reg, fc_update, fcwrten_armed, cmd_err
  );
endinterface

// File: rtl/lat_command_decoder.sv
// LAT-width command decoder for the LED-driver serial interface.
// Counts SCLK rising edges with LAT high; the first LAT-low edge after
// that decodes the command from the count. The 48-bit shift register
// content at that point is reported as cmd_data, and an FCWRTEN followed
// by WRTFC loads it into fc_reg.
// Optional build macro: FC_LEN_CHECK_EN -- an armed WRTFC only writes
// fc_reg when exactly DATA_W edges separate it from the FCWRTEN decode.
module lat_command_decoder #(
  parameter int DATA_W = 48,
  parameter int CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  lat_command_decoder_if.slave bus
);

  localparam logic [2:0] CMD_UNKNOWN   = 3'd0;
  localparam logic [2:0] CMD_WRTGS     = 3'd1;
  localparam logic [2:0] CMD_LATGS     = 3'd2;
  localparam logic [2:0] CMD_WRTFC     = 3'd3;
  localparam logic [2:0] CMD_LINERESET = 3'd4;
  localparam logic [2:0] CMD_READFC    = 3'd5;
  localparam logic [2:0] CMD_TMGRST    = 3'd6;
  localparam logic [2:0] CMD_FCWRTEN   = 3'd7;

  localparam logic [CNT_W-1:0] LAT_MAX = '1;
  localparam logic [7:0]       BIT_MAX = 8'hFF;
  localparam logic [7:0]       FC_BITS = 8'(DATA_W);

  typedef enum logic {ST_IDLE, ST_ARMED} state_t;

  logic              prev_sclk_q;
  logic              sclk_edge;
  logic              decode_edge;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0]       lat_cnt_w;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        dec_cmd;
  logic              len_ok;

  state_t            state_q, state_d;
  logic              armed;
  logic              fc_wr_d;
  logic              err_d;

  logic              cmd_valid_q;
  logic [2:0]        cmd_q;
  logic [DATA_W-1:0] cmd_data_q;
  logic [DATA_W-1:0] fc_reg_q;
  logic              fc_update_q;
  logic              cmd_err_q;

  // A rising SCLK seen on clk; prev_sclk resets low so a high SCLK at
  // reset release counts as one edge.
  assign sclk_edge   = bus.SCLK & ~prev_sclk_q;
  // LAT has fallen after at least one LAT-high edge: command complete.
  assign decode_edge = sclk_edge & ~bus.LAT & (lat_cnt_q != '0);
  assign lat_cnt_w   = 32'(lat_cnt_q);

  // SCLK history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) prev_sclk_q <= 1'b0;
    else     prev_sclk_q <= bus.SCLK;
  end

  // Next values of shift register, LAT-high counter and bit counter.
  always_comb begin
    sr_d      = sr_q;
    lat_cnt_d = lat_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (sclk_edge) begin
      // Data shifts regardless of LAT so the LAT-high bits are captured.
      sr_d = {sr_q[DATA_W-2:0], bus.SIN};
      if (bus.LAT) begin
        if (lat_cnt_q != LAT_MAX) lat_cnt_d = lat_cnt_q + 1'b1;
      end else if (lat_cnt_q != '0) begin
        lat_cnt_d = '0;
      end
      // bit_cnt counts edges since the last decode, the decode edge being 1.
      if (decode_edge)             bit_cnt_d = 8'd1;
      else if (bit_cnt_q != BIT_MAX) bit_cnt_d = bit_cnt_q + 8'd1;
    end
  end

  // Serial-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      lat_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      lat_cnt_q <= lat_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Map the LAT-high edge count to a command code; anything else is unknown.
  always_comb begin
    dec_cmd = CMD_UNKNOWN;
    case (lat_cnt_w)
      32'd1:   dec_cmd = CMD_WRTGS;
      32'd3:   dec_cmd = CMD_LATGS;
      32'd5:   dec_cmd = CMD_WRTFC;
      32'd7:   dec_cmd = CMD_LINERESET;
      32'd11:  dec_cmd = CMD_READFC;
      32'd13:  dec_cmd = CMD_TMGRST;
      32'd15:  dec_cmd = CMD_FCWRTEN;
      default: dec_cmd = CMD_UNKNOWN;
    endcase
  end

  // Frame length guard for WRTFC: bit_cnt still holds the count since the
  // FCWRTEN decode edge because it is only reloaded at this decode.
  always_comb begin
`ifdef FC_LEN_CHECK_EN
    len_ok = (bit_cnt_q == FC_BITS);
`else
    len_ok = 1'b1;
`endif
  end

  // FC sequencing FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FC sequencing FSM: any decode other than FCWRTEN disarms, including a
  // WRTFC (accepted or rejected) and unknown counts.
  always_comb begin
    state_d = state_q;
    if (decode_edge) begin
      if (dec_cmd == CMD_FCWRTEN) state_d = ST_ARMED;
      else                        state_d = ST_IDLE;
    end
  end

  // FC sequencing FSM: outputs -- armed level, FC write strobe, error.
  always_comb begin
    armed   = (state_q == ST_ARMED);
    fc_wr_d = 1'b0;
    err_d   = 1'b0;
    if (decode_edge) begin
      if (dec_cmd == CMD_UNKNOWN) begin
        err_d = 1'b1;
      end else if (dec_cmd == CMD_WRTFC) begin
        if (armed && len_ok) fc_wr_d = 1'b1;
        else                 err_d   = 1'b1;
      end
    end
  end

  // Registered decode results; pulses land one clk after the decode edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_UNKNOWN;
      cmd_data_q  <= '0;
      fc_reg_q    <= '0;
      fc_update_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_valid_q <= decode_edge;
      fc_update_q <= fc_wr_d;
      cmd_err_q   <= err_d;
      if (decode_edge) begin
        cmd_q      <= dec_cmd;
        cmd_data_q <= sr_q;
      end
      if (fc_wr_d) fc_reg_q <= sr_q;
    end
  end

  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd           = cmd_q;
  assign bus.cmd_data      = cmd_data_q;
  assign bus.fc_reg        = fc_reg_q;
  assign bus.fc_update     = fc_update_q;
  assign bus.fcwrten_armed = armed;
  assign bus.cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_lat_command_decoder.sv
// Directed bench for lat_command_decoder: serial frames driven bit by bit,
// decode pulses sampled on the falling clk edge after each SCLK edge.
module tb_lat_command_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lat_command_decoder_if #(.DATA_W(48)) bus ();

  lat_command_decoder #(.DATA_W(48), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Last SCLK edge's sampled result and pulse tallies.
  logic        p_valid, p_err, p_upd, p_armed;
  logic [2:0]  p_cmd;
  logic [47:0] p_data;
  int n_valid, n_err, n_upd, quiet_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    n_valid = 0; n_err = 0; n_upd = 0;
  endtask

  // One SCLK rising edge carrying LAT=l, SIN=s; SCLK high for one clk.
  task automatic sclk(input logic l, input logic s);
    @(negedge clk);
    bus.SCLK = 1'b1; bus.LAT = l; bus.SIN = s;
    @(negedge clk);
    bus.SCLK = 1'b0;
    p_valid = bus.cmd_valid; p_err = bus.cmd_err; p_upd = bus.fc_update;
    p_cmd   = bus.cmd;       p_data = bus.cmd_data; p_armed = bus.fcwrten_armed;
    if (p_valid) n_valid++;
    if (p_err)   n_err++;
    if (p_upd)   n_upd++;
    @(negedge clk);
    if (bus.cmd_valid || bus.cmd_err || bus.fc_update) quiet_bad++;
  endtask

  // d[n-1] .. d[0], MSB first; LAT high on the last nlat bits.
  task automatic send(input logic [47:0] d, input int n, input int nlat);
    for (int i = n - 1; i >= 0; i--) sclk(i < nlat, d[i]);
  endtask

  task automatic lat_hi(input int n);
    for (int i = 0; i < n; i++) sclk(1'b1, 1'b0);
  endtask

  logic [47:0] d;

  initial begin
    bus.SCLK = 1'b0; bus.LAT = 1'b0; bus.SIN = 1'b0;
    quiet_bad = 0;
    clr_tally();
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd", bus.cmd, 0);
    chk("rst_cmd_data", bus.cmd_data, 0);
    chk("rst_fc_reg", bus.fc_reg, 0);
    chk("rst_fc_update", bus.fc_update, 0);
    chk("rst_armed", bus.fcwrten_armed, 0);
    chk("rst_cmd_err", bus.cmd_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reference frame: FCWRTEN, 48 bits, WRTFC.
    d = 48'hA5A5_0F0F_1234;
    clr_tally();
    lat_hi(15);
    chk("ref_no_early_pulse", n_valid, 0);
    sclk(1'b0, d[47]);
    chk("ref_fcwrten_valid", p_valid, 1);
    chk("ref_fcwrten_cmd", p_cmd, 7);
    chk("ref_fcwrten_err", p_err, 0);
    chk("ref_armed_set", p_armed, 1);
    send(d, 47, 5);
    chk("ref_no_mid_pulse", n_valid, 1);
    sclk(1'b0, 1'b0);
    chk("ref_wrtfc_valid", p_valid, 1);
    chk("ref_wrtfc_cmd", p_cmd, 3);
    chk("ref_wrtfc_err", p_err, 0);
    chk("ref_fc_update", p_upd, 1);
    chk("ref_cmd_data", p_data, 48'hA5A5_0F0F_1234);
    chk("ref_armed_clr", p_armed, 0);
    chk("ref_fc_reg", bus.fc_reg, 48'hA5A5_0F0F_1234);
    chk("ref_upd_count", n_upd, 1);

    // WRTGS: one LAT-high edge.
    d = 48'h0000_00FF_FFFF;
    clr_tally();
    send(d, 48, 1);
    sclk(1'b0, 1'b0);
    chk("wrtgs_cmd", p_cmd, 1);
    chk("wrtgs_data", p_data, 48'h0000_00FF_FFFF);
    chk("wrtgs_valid_cnt", n_valid, 1);
    chk("wrtgs_err_cnt", n_err, 0);
    chk("wrtgs_upd_cnt", n_upd, 0);
    chk("wrtgs_fc_hold", bus.fc_reg, 48'hA5A5_0F0F_1234);

    // WRTFC with no FCWRTEN.
    d = 48'h1234_5678_9ABC;
    clr_tally();
    send(d, 48, 5);
    sclk(1'b0, 1'b0);
    chk("unarmed_valid", p_valid, 1);
    chk("unarmed_cmd", p_cmd, 3);
    chk("unarmed_err", p_err, 1);
    chk("unarmed_upd", p_upd, 0);
    chk("unarmed_data", p_data, 48'h1234_5678_9ABC);
    chk("unarmed_fc_hold", bus.fc_reg, 48'hA5A5_0F0F_1234);

    // Unknown counts (2, then saturated) after arming.
    lat_hi(15);
    sclk(1'b0, 1'b0);
    chk("unk_armed", p_armed, 1);
    clr_tally();
    lat_hi(2);
    sclk(1'b0, 1'b0);
    chk("unk2_cmd", p_cmd, 0);
    chk("unk2_err", p_err, 1);
    chk("unk2_disarm", p_armed, 0);
    lat_hi(40);
    sclk(1'b0, 1'b0);
    chk("sat_cmd", p_cmd, 0);
    chk("sat_err", p_err, 1);
    chk("unk_err_cnt", n_err, 2);
    chk("unk_valid_cnt", n_valid, 2);

    // Reset mid-burst drops the partial FCWRTEN.
    lat_hi(8);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_fc_reg", bus.fc_reg, 0);
    chk("midrst_armed", bus.fcwrten_armed, 0);
    rst = 1'b0;
    clr_tally();
    lat_hi(5);
    sclk(1'b0, 1'b0);
    chk("midrst_cmd", p_cmd, 3);
    chk("midrst_err", p_err, 1);
    chk("midrst_upd", p_upd, 0);
    chk("midrst_valid_cnt", n_valid, 1);
    chk("midrst_fc_zero", bus.fc_reg, 0);

    // Short FC frame: 47 bits between FCWRTEN and WRTFC.
    d = 48'h7FFF_0000_AAAA;
    clr_tally();
    lat_hi(15);
    sclk(1'b0, d[46]);
    chk("short_fcwrten", p_cmd, 7);
    send(d, 46, 5);
    sclk(1'b0, 1'b0);
    chk("short_cmd", p_cmd, 3);
    chk("short_disarm", p_armed, 0);
`ifdef FC_LEN_CHECK_EN
    chk("short_err", p_err, 1);
    chk("short_upd", p_upd, 0);
    chk("short_fc_hold", bus.fc_reg, 0);
`else
    chk("short_err", p_err, 0);
    chk("short_upd", p_upd, 1);
    chk("short_fc_reg", bus.fc_reg, 48'h7FFF_0000_AAAA);
`endif

    chk("quiet_between_pulses", quiet_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
